// File: rtl/ysyx_23060221_axi_pkg.sv
// ysyx_23060221_axi_pkg: shared AXI encodings, arbiter states and master indices
package ysyx_23060221_axi_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;
endpackage

// File: rtl/ysyx_23060221_axi_rd_arb_if.sv
// ysyx_23060221_axi_rd_arb_if: AXI4 read address + read data channel bundle
interface ysyx_23060221_axi_rd_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;
    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );
    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060221_rr_pick2.sv
// ysyx_23060221_rr_pick2: two-way round-robin picker; on a tie the master that was not last served wins
module ysyx_23060221_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);
    assign grant = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/ysyx_23060221_axi_rd_arb.sv
// ysyx_23060221_axi_rd_arb: round-robin AXI4 read-channel arbiter, IFU (m0) and LSU (m1) onto one slave
module ysyx_23060221_axi_rd_arb
    import ysyx_23060221_axi_pkg::*;
(
    input logic                          clk,
    input logic                          rst,
    ysyx_23060221_axi_rd_arb_if.slave    m0,
    ysyx_23060221_axi_rd_arb_if.slave    m1,
    ysyx_23060221_axi_rd_arb_if.master   s
);
    state_t state, state_n;
    logic   grant, grant_n, last, last_n, pick, ar_valid, r_ready;

    ysyx_23060221_rr_pick2 u_pick (
        .req   ({m1.arvalid, m0.arvalid}),
        .last  (last),
        .grant (pick)
    );

    assign s.araddr  = grant ? m1.araddr  : m0.araddr;
    assign s.arid    = grant ? m1.arid    : m0.arid;
    assign s.arlen   = grant ? m1.arlen   : m0.arlen;
    assign s.arsize  = grant ? m1.arsize  : m0.arsize;
    assign s.arburst = grant ? m1.arburst : m0.arburst;
    assign ar_valid  = grant ? m1.arvalid : m0.arvalid;
    assign r_ready   = grant ? m1.rready  : m0.rready;
    assign m0.rdata  = s.rdata;
    assign m0.rresp  = s.rresp;
    assign m0.rlast  = s.rlast;
    assign m0.rid    = s.rid;
    assign m1.rdata  = s.rdata;
    assign m1.rresp  = s.rresp;
    assign m1.rlast  = s.rlast;
    assign m1.rid    = s.rid;

    // state, grant and last-served registers; reset lets IFU win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= M_IFU;
            last  <= M_LSU;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
        end
    end

    // next state and handshake steering; the loser never sees arready or rvalid
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        last_n     = last;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (m0.arvalid | m1.arvalid) begin
                    grant_n = pick;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                s.arvalid  = ar_valid;
                m0.arready = ~grant & s.arready;
                m1.arready = grant & s.arready;
                if (ar_valid & s.arready) begin
                    state_n = DATA;
                    last_n  = grant;
                end
            end
            DATA: begin
                s.rready  = r_ready;
                m0.rvalid = ~grant & s.rvalid;
                m1.rvalid = grant & s.rvalid;
                if (s.rvalid & r_ready & s.rlast) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060221_axi_rd_arb.sv
// tb_ysyx_23060221_axi_rd_arb: directed checks of arbitration, bursts, stalls, errors and reset
module tb_ysyx_23060221_axi_rd_arb;
    import ysyx_23060221_axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ysyx_23060221_axi_rd_arb_if m0_bus ();
    ysyx_23060221_axi_rd_arb_if m1_bus ();
    ysyx_23060221_axi_rd_arb_if s_bus ();

    ysyx_23060221_axi_rd_arb dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one single-beat read, entered from IDLE with the request already raised
    task automatic serve(input logic m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        step();
        chk("addr_arvalid", s_bus.arvalid, 1);
        chk("addr_araddr", s_bus.araddr, a);
        chk("addr_win_arready", m ? m1_bus.arready : m0_bus.arready, 1);
        chk("addr_lose_arready", m ? m0_bus.arready : m1_bus.arready, 0);
        step();
        if (m) m1_bus.arvalid = 1'b0;
        else m0_bus.arvalid = 1'b0;
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = d;
        s_bus.rresp  = resp;
        s_bus.rlast  = 1'b1;
        #1;
        chk("data_win_rvalid", m ? m1_bus.rvalid : m0_bus.rvalid, 1);
        chk("data_lose_rvalid", m ? m0_bus.rvalid : m1_bus.rvalid, 0);
        chk("data_rdata", m ? m1_bus.rdata : m0_bus.rdata, d);
        chk("data_rresp", m ? m1_bus.rresp : m0_bus.rresp, {30'd0, resp});
        step();
        s_bus.rvalid = 1'b0;
        s_bus.rlast  = 1'b0;
        s_bus.rresp  = RESP_OKAY;
        #1;
        chk("idle_arvalid", s_bus.arvalid, 0);
        chk("idle_m0_arready", m0_bus.arready, 0);
        chk("idle_m1_arready", m1_bus.arready, 0);
    endtask

    initial begin
        int beat;
        m0_bus.arvalid = 0; m0_bus.araddr = 0; m0_bus.arid = 4'h1; m0_bus.arlen = 0;
        m0_bus.arsize = 3'b010; m0_bus.arburst = BURST_INCR; m0_bus.rready = 1;
        m1_bus.arvalid = 0; m1_bus.araddr = 0; m1_bus.arid = 4'h2; m1_bus.arlen = 0;
        m1_bus.arsize = 3'b010; m1_bus.arburst = BURST_INCR; m1_bus.rready = 1;
        s_bus.arready = 1; s_bus.rvalid = 0; s_bus.rdata = 0; s_bus.rresp = 0;
        s_bus.rlast = 0; s_bus.rid = 0;
        step();
        step();
        rst = 1'b0;
        chk("rst_s_arvalid", s_bus.arvalid, 0);
        chk("rst_s_rready", s_bus.rready, 0);
        chk("rst_m0_arready", m0_bus.arready, 0);
        chk("rst_m1_arready", m1_bus.arready, 0);
        s_bus.rvalid = 1'b1;
        #1;
        chk("stray_m0_rvalid", m0_bus.rvalid, 0);
        chk("stray_m1_rvalid", m1_bus.rvalid, 0);
        chk("stray_s_rready", s_bus.rready, 0);
        s_bus.rvalid = 1'b0;
        // single IFU fetch: arbitration cycle shows nothing on the slave yet
        m0_bus.arvalid = 1'b1;
        m0_bus.araddr  = 32'h8000_0000;
        #1;
        chk("arb_cycle_arvalid", s_bus.arvalid, 0);
        serve(M_IFU, 32'h8000_0000, 32'h0000_0413, RESP_OKAY);
        // contention right after reset: m0, m1, then alternating m0, m1
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h100;
        m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h200;
        serve(M_IFU, 32'h100, 32'h11, RESP_OKAY);
        serve(M_LSU, 32'h200, 32'h22, RESP_OKAY);
        m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h104;
        m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h204;
        serve(M_IFU, 32'h104, 32'h33, RESP_OKAY);
        serve(M_LSU, 32'h204, 32'h44, RESP_OKAY);
        // m1 requests while m0 waits 5 cycles for its data
        m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h300;
        step();
        step();
        m0_bus.arvalid = 1'b0;
        m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h310;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_m1_arready", m1_bus.arready, 0);
            chk("stall_s_arvalid", s_bus.arvalid, 0);
            chk("stall_m0_rvalid", m0_bus.rvalid, 0);
            step();
        end
        s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; s_bus.rdata = 32'h55;
        #1;
        chk("stall_m0_beat", m0_bus.rvalid, 1);
        chk("stall_m1_rvalid", m1_bus.rvalid, 0);
        step();
        s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0;
        #1;
        chk("stall_idle_m1_arready", m1_bus.arready, 0);
        serve(M_LSU, 32'h310, 32'h66, RESP_OKAY);
        // LSU 4-beat burst with a back-pressure bubble on the second beat
        m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h400; m1_bus.arlen = 8'd3;
        step();
        chk("burst_arlen", {24'd0, s_bus.arlen}, 32'd3);
        step();
        m1_bus.arvalid = 1'b0;
        beat = 0;
        for (int c = 0; c < 5; c++) begin
            m1_bus.rready = (c != 1);
            s_bus.rvalid  = 1'b1;
            s_bus.rdata   = 32'hA0 + beat;
            s_bus.rlast   = (beat == 3);
            #1;
            chk("burst_m1_rvalid", m1_bus.rvalid, 1);
            chk("burst_m1_rdata", m1_bus.rdata, 32'hA0 + beat);
            chk("burst_s_rready", s_bus.rready, {31'd0, c != 1});
            chk("burst_m0_rvalid", m0_bus.rvalid, 0);
            if (c != 1) beat++;
            step();
        end
        s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0; m1_bus.rready = 1'b1; m1_bus.arlen = 0;
        #1;
        chk("burst_released", m1_bus.rvalid, 0);
        // error response passes through and the grant still ends normally
        m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h500;
        serve(M_IFU, 32'h500, 32'hDEAD, RESP_SLVERR);
        // reset pulse while the address phase is stalled
        s_bus.arready = 1'b0;
        m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h600;
        step();
        chk("rst_addr_arvalid", s_bus.arvalid, 1);
        chk("rst_addr_arready", m0_bus.arready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_arvalid", s_bus.arvalid, 0);
        m0_bus.arvalid = 1'b0;
        s_bus.arready  = 1'b1;
        m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h700;
        serve(M_LSU, 32'h700, 32'h77, RESP_OKAY);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
